// File: rtl/melody_sequencer.sv
// Score player: walks a (note, octave, duration) ROM at a programmable tempo and
// drives note/octave to the pitch generator, with pause, looping and articulation gaps.
module melody_sequencer #(
  parameter int ADDR_WIDTH = 8,
  parameter int GAP_TICKS  = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  pause,
  input  logic                  loop_en,
  input  logic [31:0]           tick_len,
  output logic [ADDR_WIDTH-1:0] score_addr,
  input  logic [15:0]           score_data,
  output logic [3:0]            note,
  output logic [3:0]            octave,
  output logic                  playing,
  output logic                  song_done
);

  typedef enum logic [2:0] {IDLE, FETCH, PLAY, PAUSED, DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_MAX = '1;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = ADDR_WIDTH'(1);
  localparam logic [7:0]            GAP      = 8'(GAP_TICKS);

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   addr_nx;
  logic [3:0]              note_q, note_nx;
  logic [3:0]              oct_q, oct_nx;
  logic [7:0]              dur_q, dur_nx;
  logic [7:0]              rem_q, rem_nx;
  logic [31:0]             tick_q, tick_nx;
  logic                    end_pend, end_pend_nx;
  logic                    done_nx;

  // Last tick-counter value before a wrap; a zero tick_len behaves as one.
  function automatic logic [31:0] tick_last(input logic [31:0] len);
    return (len == 32'd0) ? 32'd0 : len - 32'd1;
  endfunction

  always_comb begin
    state_nx    = state;
    addr_nx     = score_addr;
    note_nx     = note_q;
    oct_nx      = oct_q;
    dur_nx      = dur_q;
    rem_nx      = rem_q;
    tick_nx     = tick_q;
    end_pend_nx = end_pend;
    done_nx     = 1'b0;
    if (stop) begin
      state_nx    = IDLE;
      addr_nx     = '0;
      rem_nx      = 8'd0;
      tick_nx     = 32'd0;
      end_pend_nx = 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state_nx    = FETCH;
            addr_nx     = '0;
            end_pend_nx = 1'b0;
          end
        end
        FETCH: begin
          // end_pend marks a fetch past the last address: handled like an end marker.
          if (score_data[7:0] != 8'd0 && !end_pend) begin
            note_nx  = score_data[15:12];
            oct_nx   = score_data[11:8];
            dur_nx   = score_data[7:0];
            rem_nx   = score_data[7:0];
            tick_nx  = 32'd0;
            state_nx = PLAY;
          end else if (loop_en && (end_pend || score_addr != '0)) begin
            addr_nx     = '0;
            end_pend_nx = 1'b0;
          end else begin
            state_nx    = DONE;
            done_nx     = 1'b1;
            end_pend_nx = 1'b0;
          end
        end
        PLAY, PAUSED: begin
          // A paused cycle is frozen; the cycle that leaves PAUSED counts, so the
          // frozen PLAY cycle that entered the pause is paid back exactly.
          if (pause) begin
            state_nx = PAUSED;
          end else begin
            state_nx = PLAY;
            if (tick_q >= tick_last(tick_len)) begin
              tick_nx = 32'd0;
              rem_nx  = rem_q - 8'd1;
              if (rem_q <= 8'd1) begin
                state_nx = FETCH;
                if (score_addr == ADDR_MAX) end_pend_nx = 1'b1;
                else                        addr_nx     = score_addr + ADDR_ONE;
              end
            end else begin
              tick_nx = tick_q + 32'd1;
            end
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      score_addr <= '0;
      note_q     <= 4'd0;
      oct_q      <= 4'd0;
      dur_q      <= 8'd0;
      rem_q      <= 8'd0;
      tick_q     <= 32'd0;
      end_pend   <= 1'b0;
      song_done  <= 1'b0;
    end else begin
      state      <= state_nx;
      score_addr <= addr_nx;
      note_q     <= note_nx;
      oct_q      <= oct_nx;
      dur_q      <= dur_nx;
      rem_q      <= rem_nx;
      tick_q     <= tick_nx;
      end_pend   <= end_pend_nx;
      song_done  <= done_nx;
    end
  end

  // Notes no longer than the gap play in full; longer ones fall silent for the last GAP ticks.
  assign note    = (state == PLAY && (rem_q > GAP || dur_q <= GAP)) ? note_q : 4'd0;
  assign octave  = oct_q;
  assign playing = (state == FETCH) || (state == PLAY) || (state == PAUSED);

endmodule

// File: tb/tb_melody_sequencer.sv
// Bench for melody_sequencer: per-cycle expectations are queued when a song is
// started and popped as the sequencer plays it.
module tb_melody_sequencer;

  logic        clk = 1'b0;
  logic        rst_n, start, stop, pause, loop_en;
  logic [31:0] tick_len;
  logic [7:0]  score_addr;
  logic [15:0] score_data;
  logic [3:0]  note, octave;
  logic        playing, song_done;

  logic        start2;
  logic [1:0]  score_addr2;
  logic [15:0] score_data2;
  logic [3:0]  note2, octave2;
  logic        playing2, song_done2;

  logic [15:0] rom  [0:255];
  logic [15:0] rom2 [0:3];

  int n_cmp = 0;
  int n_err = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  assign score_data  = rom[score_addr];
  assign score_data2 = rom2[score_addr2];

  melody_sequencer #(.ADDR_WIDTH(8), .GAP_TICKS(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .pause(pause),
    .loop_en(loop_en), .tick_len(tick_len), .score_addr(score_addr),
    .score_data(score_data), .note(note), .octave(octave),
    .playing(playing), .song_done(song_done)
  );

  melody_sequencer #(.ADDR_WIDTH(2), .GAP_TICKS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .stop(stop), .pause(pause),
    .loop_en(loop_en), .tick_len(tick_len), .score_addr(score_addr2),
    .score_data(score_data2), .note(note2), .octave(octave2),
    .playing(playing2), .song_done(song_done2)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cmp_pop(input string tag, input logic [31:0] got);
    if (exp_q.size() == 0) chk({tag, "_sb_underflow"}, 32'd1, 32'd0);
    else                   chk(tag, got, exp_q.pop_front());
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int play_cnt, note_cnt, cyc, ph, done_cnt;
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0; loop_en = 1'b0;
    start2 = 1'b0; tick_len = 32'd4;
    clear_rom();
    for (int i = 0; i < 4; i++) rom2[i] = 16'h0000;
    step();
    chk("rst_addr", score_addr, 0);
    chk("rst_note", note, 0);
    chk("rst_octave", octave, 0);
    chk("rst_playing", playing, 0);
    chk("rst_song_done", song_done, 0);
    step();
    rst_n = 1'b1;
    step();

    // Basic: 3-tick note with a one-tick gap, then end marker.
    rom[0] = 16'h5403; rom[1] = 16'h0000; tick_len = 32'd4; loop_en = 1'b0;
    for (int c = 1; c <= 16; c++)
      exp_q.push_back((((c >= 2 && c <= 9) ? 5 : 0) << 2) | ((c <= 14) ? 2 : 0) | ((c == 15) ? 1 : 0));
    pulse_start();
    for (int c = 1; c <= 16; c++) begin
      cmp_pop("basic_trace", {note, playing, song_done});
      if (c == 2)  chk("basic_octave", octave, 4);
      if (c == 14) chk("basic_addr_fetch2", score_addr, 1);
      step();
    end
    chk("basic_addr_held", score_addr, 1);

    // tick_len=0 acts as 1; duration 1 plays in full with no gap.
    rom[0] = 16'h7301; rom[1] = 16'h0000; tick_len = 32'd0;
    exp_q.push_back(2); exp_q.push_back((7 << 2) | 2); exp_q.push_back(2);
    exp_q.push_back(1); exp_q.push_back(0);
    pulse_start();
    for (int c = 1; c <= 5; c++) begin
      cmp_pop("tick0_trace", {note, playing, song_done});
      step();
    end

    // Loop: period 2*tick_len+2, address 0,1,0,1..., never song_done.
    rom[0] = 16'h1302; rom[1] = 16'h0000; tick_len = 32'd2; loop_en = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      ph = (c - 1) % 6;
      exp_q.push_back((((ph == 1 || ph == 2) ? 1 : 0) << 8) | ((ph == 5) ? 1 : 0));
    end
    done_cnt = 0;
    pulse_start();
    for (int c = 1; c <= 18; c++) begin
      cmp_pop("loop_trace", {20'd0, note, score_addr});
      if (song_done) done_cnt++;
      step();
    end
    chk("loop_no_done", done_cnt, 0);
    stop = 1'b1; step(); stop = 1'b0;

    // Empty score with looping enabled must terminate.
    rom[0] = 16'h0000;
    exp_q.push_back(2); exp_q.push_back(1);
    for (int c = 3; c <= 6; c++) exp_q.push_back(0);
    pulse_start();
    for (int c = 1; c <= 6; c++) begin
      cmp_pop("empty_trace", {note, playing, song_done});
      step();
    end

    // Pause for 17 cycles mid-note: time stretches by 17, sounding time does not.
    rom[0] = 16'h2505; rom[1] = 16'h0000; tick_len = 32'd10; loop_en = 1'b0;
    exp_q.push_back(69); exp_q.push_back(40); exp_q.push_back(69);
    play_cnt = 0; note_cnt = 0; cyc = 0;
    pulse_start();
    while (cyc < 300 && !song_done) begin
      if (playing) play_cnt++;
      if (note != 4'd0) note_cnt++;
      if (cyc == 14) begin
        pause = 1'b1;
        for (int i = 0; i < 17; i++) begin
          step(); cyc++;
          if (playing) play_cnt++;
          chk("pause_note_silent", note, 0);
        end
        pause = 1'b0;
      end
      step(); cyc++;
    end
    chk("pause_song_done_seen", song_done, 1);
    cmp_pop("pause_playing_cycles", play_cnt);
    cmp_pop("pause_note_cycles", note_cnt);
    cmp_pop("pause_done_cycle", cyc);

    // Stop mid-note.
    rom[0] = 16'h1101; rom[1] = 16'h2505; rom[2] = 16'h0000; tick_len = 32'd2;
    pulse_start();
    repeat (6) step();
    chk("stop_pre_addr", score_addr, 1);
    chk("stop_pre_note", note, 2);
    stop = 1'b1; step(); stop = 1'b0;
    chk("stop_note", note, 0);
    chk("stop_playing", playing, 0);
    chk("stop_addr", score_addr, 0);

    // Asynchronous reset mid-note, checked before any clock edge.
    pulse_start();
    repeat (6) step();
    chk("arst_pre_note", note, 2);
    rst_n = 1'b0;
    #1;
    chk("arst_addr", score_addr, 0);
    chk("arst_note", note, 0);
    chk("arst_octave", octave, 0);
    chk("arst_playing", playing, 0);
    chk("arst_song_done", song_done, 0);
    step();
    rst_n = 1'b1;
    step();

    // ADDR_WIDTH=2, all four entries valid: ends after address 3.
    rom2[0] = 16'h1101; rom2[1] = 16'h2201; rom2[2] = 16'h3301; rom2[3] = 16'h4401;
    tick_len = 32'd1; loop_en = 1'b0;
    for (int c = 1; c <= 10; c++)
      exp_q.push_back((((c % 2 == 0 && c <= 8) ? c / 2 : 0) << 1) | ((c == 10) ? 1 : 0));
    start2 = 1'b1; step(); start2 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      cmp_pop("aw2_trace", {note2, song_done2});
      if (c == 10) chk("aw2_addr_done", score_addr2, 3);
      step();
    end
    chk("aw2_idle_after", playing2, 0);

    chk("sb_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
